// File: rtl/seq_scan_mux.sv
// Registered N-channel multiplexer that serves single DIRECT selections or one SCAN pass
// over a channel mask, with a programmable dwell per channel and a valid/ready output register.
module seq_scan_mux #(
  parameter int N_CH    = 16,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = $clog2(N_CH),
  parameter int DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     mode,
  input  logic [N_CH-1:0]          ch_mask,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic                     start,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, DWELL, HOLD} state_t;

  state_t               state, state_nx;
  logic                 mode_r, mode_nx;
  logic [N_CH-1:0]      mask_r, mask_nx;
  logic [DWELL_W-1:0]   dwell_r, dwell_nx;
  logic [DWELL_W-1:0]   cnt, cnt_nx;
  logic [SEL_W-1:0]     ptr, ptr_nx;
  logic [DATA_W-1:0]    data_nx;
  logic [SEL_W-1:0]     ch_nx;
  logic                 valid_nx, done_nx, err_nx;
  logic [SEL_W:0]       first_bit, next_bit;
  logic                 sel_ok;

  function automatic logic [DATA_W-1:0] chan(input logic [N_CH*DATA_W-1:0] bus,
                                             input logic [SEL_W-1:0] idx);
    chan = '0;
    for (int k = 0; k < N_CH; k++)
      if (idx == SEL_W'(k)) chan = bus[k*DATA_W +: DATA_W];
  endfunction

  // Returns {found, index} of the lowest set mask bit at or above lo.
  function automatic logic [SEL_W:0] find_set(input logic [N_CH-1:0] m, input int lo);
    find_set = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (k >= lo && m[k]) find_set = {1'b1, SEL_W'(k)};
  endfunction

  function automatic logic [DWELL_W-1:0] dwell_len(input logic [DWELL_W-1:0] d);
    dwell_len = (d == '0) ? DWELL_W'(1) : d;
  endfunction

  assign first_bit = find_set(ch_mask, 0);
  assign next_bit  = find_set(mask_r, int'(ptr) + 1);
  assign sel_ok    = ({1'b0, sel} < (SEL_W+1)'(N_CH));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    mode_nx  = mode_r;
    mask_nx  = mask_r;
    dwell_nx = dwell_r;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    data_nx  = out_data;
    ch_nx    = out_ch;
    valid_nx = out_valid;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode_nx  = mode;
          mask_nx  = ch_mask;
          dwell_nx = dwell;
          if (!mode) begin
            if (sel_ok) begin
              data_nx  = chan(in_data, sel);
              ch_nx    = sel;
              valid_nx = 1'b1;
              state_nx = HOLD;
            end else begin
              err_nx = 1'b1;
            end
          end else if (!first_bit[SEL_W]) begin
            err_nx = 1'b1;
          end else begin
            ptr_nx   = first_bit[SEL_W-1:0];
            cnt_nx   = dwell_len(dwell);
            state_nx = DWELL;
          end
        end
      end
      DWELL: begin
        // Sample on the last dwell cycle so the channel has fully settled.
        if (cnt <= DWELL_W'(1)) begin
          data_nx  = chan(in_data, ptr);
          ch_nx    = ptr;
          valid_nx = 1'b1;
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt - DWELL_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_nx = 1'b0;
          if (mode_r && next_bit[SEL_W]) begin
            ptr_nx   = next_bit[SEL_W-1:0];
            cnt_nx   = dwell_len(dwell_r);
            state_nx = DWELL;
          end else begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_r    <= 1'b0;
      mask_r    <= '0;
      dwell_r   <= '0;
      cnt       <= '0;
      ptr       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      mode_r    <= mode_nx;
      mask_r    <= mask_nx;
      dwell_r   <= dwell_nx;
      cnt       <= cnt_nx;
      ptr       <= ptr_nx;
      out_data  <= data_nx;
      out_ch    <= ch_nx;
      out_valid <= valid_nx;
      done      <= done_nx;
      err       <= err_nx;
    end
  end

endmodule

// File: tb/tb_seq_scan_mux.sv
// Bench for seq_scan_mux: directed scenarios on a 16x8 build, randomized requests on a 5x12
// build checked against a channel-list reference model.
module tb_seq_scan_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16 channels x 8 bits
  logic [127:0] a_in;
  logic [3:0]   a_sel;
  logic         a_mode;
  logic [15:0]  a_mask;
  logic [7:0]   a_dwell;
  logic         a_start, a_ready;
  logic [7:0]   a_data;
  logic [3:0]   a_ch;
  logic         a_valid, a_busy, a_done, a_err;

  // 5 channels x 12 bits
  logic [59:0]  b_in;
  logic [2:0]   b_sel;
  logic         b_mode;
  logic [4:0]   b_mask;
  logic [7:0]   b_dwell;
  logic         b_start, b_ready;
  logic [11:0]  b_data;
  logic [2:0]   b_ch;
  logic         b_valid, b_busy, b_done, b_err;

  int checks = 0;
  int errors = 0;

  seq_scan_mux #(.N_CH(16), .DATA_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in), .sel(a_sel), .mode(a_mode), .ch_mask(a_mask),
    .dwell(a_dwell), .start(a_start), .out_data(a_data), .out_ch(a_ch), .out_valid(a_valid),
    .out_ready(a_ready), .busy(a_busy), .done(a_done), .err(a_err));

  seq_scan_mux #(.N_CH(5), .DATA_W(12)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in), .sel(b_sel), .mode(b_mode), .ch_mask(b_mask),
    .dwell(b_dwell), .start(b_start), .out_data(b_data), .out_ch(b_ch), .out_valid(b_valid),
    .out_ready(b_ready), .busy(b_busy), .done(b_done), .err(b_err));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    a_in = '0; a_sel = '0; a_mode = 1'b0; a_mask = '0; a_dwell = '0; a_start = 1'b0; a_ready = 1'b0;
    b_in = '0; b_sel = '0; b_mode = 1'b0; b_mask = '0; b_dwell = '0; b_start = 1'b0; b_ready = 1'b0;
    #2 rst_n = 1'b0;
    tick; tick;
    checks++;
    if ({a_valid, a_busy, a_done, a_err, a_data, a_ch} !== 16'h0) begin
      errors++;
      $display("FAIL reset_a got %h required 0", {a_valid, a_busy, a_done, a_err, a_data, a_ch});
    end
    checks++;
    if ({b_valid, b_busy, b_done, b_err, b_data, b_ch} !== 19'h0) begin
      errors++;
      $display("FAIL reset_b got %h required 0", {b_valid, b_busy, b_done, b_err, b_data, b_ch});
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_direct;
    a_in = '0; a_in[5*8 +: 8] = 8'hA5; a_sel = 4'd5; a_mode = 1'b0; a_ready = 1'b1;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    checks++;
    if ({a_valid, a_busy, a_ch, a_data} !== {1'b1, 1'b1, 4'd5, 8'hA5}) begin
      errors++;
      $display("FAIL direct_beat got v=%b b=%b ch=%0d d=%h required v=1 b=1 ch=5 d=a5",
               a_valid, a_busy, a_ch, a_data);
    end
    tick;
    checks++;
    if ({a_valid, a_done, a_busy, a_err} !== 4'b0100) begin
      errors++;
      $display("FAIL direct_done got v/done/busy/err=%b required 0100", {a_valid, a_done, a_busy, a_err});
    end
    tick;
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("FAIL direct_done_pulse got %b required 0", a_done);
    end
  endtask

  task automatic test_backpressure;
    a_in = '0; a_in[5*8 +: 8] = 8'hA5; a_sel = 4'd5; a_mode = 1'b0; a_ready = 1'b0;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    a_in[5*8 +: 8] = 8'h3C;
    a_sel = 4'd2;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if ({a_valid, a_ch, a_data, a_done} !== {1'b1, 4'd5, 8'hA5, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b ch=%0d d=%h done=%b required v=1 ch=5 d=a5 done=0",
                 i, a_valid, a_ch, a_data, a_done);
      end
    end
    a_ready = 1'b1;
    tick;
    checks++;
    if ({a_valid, a_done, a_busy} !== 3'b010) begin
      errors++;
      $display("FAIL bp_done got v/done/busy=%b required 010", {a_valid, a_done, a_busy});
    end
  endtask

  task automatic test_scan;
    int exp_ch[3];
    exp_ch = '{0, 4, 15};
    for (int k = 0; k < 16; k++) a_in[k*8 +: 8] = 8'(k);
    a_mask = 16'h8011; a_dwell = 8'd3; a_mode = 1'b1; a_ready = 1'b1;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    a_mask = 16'h0000; a_dwell = 8'd9;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin
        tick;
        checks++;
        if ({a_valid, a_done, a_busy} !== 3'b001) begin
          errors++;
          $display("FAIL scan_gap beat %0d got v/done/busy=%b required 001", b, {a_valid, a_done, a_busy});
        end
      end
      for (int c = 1; c <= 3; c++) begin
        tick;
        if (c < 3) begin
          checks++;
          if ({a_valid, a_busy} !== 2'b01) begin
            errors++;
            $display("FAIL scan_dwell beat %0d cyc %0d got v/busy=%b required 01", b, c, {a_valid, a_busy});
          end
        end else begin
          checks++;
          if ({a_valid, a_ch, a_data} !== {1'b1, 4'(exp_ch[b]), 8'(exp_ch[b])}) begin
            errors++;
            $display("FAIL scan_beat %0d got v=%b ch=%0d d=%h required v=1 ch=%0d d=%0d",
                     b, a_valid, a_ch, a_data, exp_ch[b], exp_ch[b]);
          end
        end
      end
    end
    tick;
    checks++;
    if ({a_valid, a_done, a_busy, a_err} !== 4'b0100) begin
      errors++;
      $display("FAIL scan_done got v/done/busy/err=%b required 0100", {a_valid, a_done, a_busy, a_err});
    end
  endtask

  task automatic test_scan_edges;
    // dwell=0 behaves as a single-cycle dwell
    a_mask = 16'h0006; a_dwell = 8'd0; a_mode = 1'b1; a_ready = 1'b1;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    tick;
    checks++;
    if ({a_valid, a_ch, a_data} !== {1'b1, 4'd1, 8'd1}) begin
      errors++;
      $display("FAIL dwell0_beat1 got v=%b ch=%0d d=%h required v=1 ch=1 d=01", a_valid, a_ch, a_data);
    end
    tick;
    tick;
    checks++;
    if ({a_valid, a_ch, a_data} !== {1'b1, 4'd2, 8'd2}) begin
      errors++;
      $display("FAIL dwell0_beat2 got v=%b ch=%0d d=%h required v=1 ch=2 d=02", a_valid, a_ch, a_data);
    end
    tick;
    checks++;
    if ({a_done, a_busy} !== 2'b10) begin
      errors++;
      $display("FAIL dwell0_done got done/busy=%b required 10", {a_done, a_busy});
    end
    // empty mask is rejected
    a_mask = 16'h0000;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    checks++;
    if ({a_err, a_valid, a_busy, a_done} !== 4'b1000) begin
      errors++;
      $display("FAIL mask0_err got err/v/busy/done=%b required 1000", {a_err, a_valid, a_busy, a_done});
    end
    tick;
    checks++;
    if ({a_err, a_valid} !== 2'b00) begin
      errors++;
      $display("FAIL mask0_clear got err/v=%b required 00", {a_err, a_valid});
    end
    // start while busy is ignored
    a_mask = 16'h8000; a_dwell = 8'd5;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    tick;
    a_mode = 1'b0; a_sel = 4'd3; a_start = 1'b1;
    tick;
    a_start = 1'b0;
    checks++;
    if ({a_err, a_valid, a_busy} !== 3'b001) begin
      errors++;
      $display("FAIL busy_start got err/v/busy=%b required 001", {a_err, a_valid, a_busy});
    end
    tick; tick; tick;
    checks++;
    if ({a_valid, a_ch, a_data} !== {1'b1, 4'd15, 8'd15}) begin
      errors++;
      $display("FAIL busy_beat got v=%b ch=%0d d=%h required v=1 ch=15 d=0f", a_valid, a_ch, a_data);
    end
    tick;
    checks++;
    if ({a_done, a_busy, a_err} !== 3'b100) begin
      errors++;
      $display("FAIL busy_done got done/busy/err=%b required 100", {a_done, a_busy, a_err});
    end
  endtask

  task automatic test_reset_mid_scan;
    a_mask = 16'h8011; a_dwell = 8'd3; a_mode = 1'b1; a_ready = 1'b1;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    tick; tick; tick;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_valid, a_busy, a_done, a_err, a_data, a_ch} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid got %h required 0", {a_valid, a_busy, a_done, a_err, a_data, a_ch});
    end
    #2 rst_n = 1'b1;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    tick; tick; tick;
    checks++;
    if ({a_valid, a_ch, a_data} !== {1'b1, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_rescan got v=%b ch=%0d d=%h required v=1 ch=0 d=00", a_valid, a_ch, a_data);
    end
  endtask

  function automatic logic [11:0] ch5(input logic [59:0] v, input int k);
    return v[k*12 +: 12];
  endfunction

  logic [59:0] applied_in;

  task automatic tick_b;
    applied_in = b_in;
    tick;
    b_start = 1'b0;
    b_in    = 60'({$urandom, $urandom});
    b_ready = ($urandom_range(0, 2) != 0);
    b_sel   = 3'($urandom);
    b_mode  = 1'($urandom);
    b_mask  = 5'($urandom);
    b_dwell = 8'($urandom_range(0, 3));
  endtask

  task automatic test_random;
    int q[$];
    int lat, n;
    logic hs, last;
    logic [11:0] beat;
    for (int t = 0; t < 60; t++) begin
      b_mode  = 1'($urandom);
      b_sel   = 3'($urandom);
      b_mask  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      b_dwell = 8'($urandom_range(0, 3));
      q.delete();
      if (!b_mode) begin
        if (b_sel < 3'd5) q.push_back(int'(b_sel));
      end else begin
        for (int k = 0; k < 5; k++) if (b_mask[k]) q.push_back(k);
      end
      lat = !b_mode ? 0 : (b_dwell == 8'd0 ? 1 : int'(b_dwell));
      b_start = 1'b1;
      tick_b;
      if (q.size() == 0) begin
        checks++;
        if ({b_err, b_valid, b_busy, b_done} !== 4'b1000) begin
          errors++;
          $display("FAIL rand_err txn %0d got err/v/busy/done=%b required 1000", t, {b_err, b_valid, b_busy, b_done});
        end
        continue;
      end
      for (int i = 0; i < q.size(); i++) begin
        for (int c = 1; c <= lat; c++) begin
          tick_b;
          if (c < lat) begin
            checks++;
            if ({b_valid, b_busy} !== 2'b01) begin
              errors++;
              $display("FAIL rand_dwell txn %0d got v/busy=%b required 01", t, {b_valid, b_busy});
            end
          end
        end
        beat = ch5(applied_in, q[i]);
        checks++;
        if ({b_valid, b_err, b_ch, b_data} !== {1'b1, 1'b0, 3'(q[i]), beat}) begin
          errors++;
          $display("FAIL rand_beat txn %0d got v=%b err=%b ch=%0d d=%h required v=1 err=0 ch=%0d d=%h",
                   t, b_valid, b_err, b_ch, b_data, q[i], beat);
        end
        n = 0;
        do begin
          hs = b_ready;
          tick_b;
          n++;
          if (!hs) begin
            checks++;
            if ({b_valid, b_ch, b_data} !== {1'b1, 3'(q[i]), beat}) begin
              errors++;
              $display("FAIL rand_hold txn %0d got v=%b ch=%0d d=%h required v=1 ch=%0d d=%h",
                       t, b_valid, b_ch, b_data, q[i], beat);
            end
          end
        end while (!hs && n < 100);
        if (!hs) begin
          checks++;
          errors++;
          $display("FAIL rand_timeout txn %0d got no handshake required handshake within 100 cycles", t);
        end
        last = (i == q.size() - 1);
        checks++;
        if ({b_valid, b_busy, b_done} !== (last ? 3'b001 : 3'b010)) begin
          errors++;
          $display("FAIL rand_after_hs txn %0d got v/busy/done=%b required %b",
                   t, {b_valid, b_busy, b_done}, (last ? 3'b001 : 3'b010));
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_direct;
    test_backpressure;
    test_scan;
    test_scan_edges;
    test_reset_mid_scan;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
